// File: rtl/rom_load_sched.sv
// rtl/rom_load_sched.sv - ROM download sequencer and shared memory-port scheduler
//
// Purpose: buffers index-0 ioctl download bytes in a small write FIFO. It shares one
// request/acknowledge memory port between buffered writes and CPU program-ROM reads.
// It latches the index-1 machine-select byte. It holds the game core in reset until
// the image is fully committed and a settle delay has elapsed.
//
// Optional feature macro: ROM_LOAD_CHECKSUM_EN (8-bit wrapping sum of accepted
// index-0 bytes on dl_sum; when undefined dl_sum is tied to zero).
//
// Ports:
//   clk_sys, reset_n           clock (rising edge), asynchronous active-low reset
//   ioctl_download/wr/addr/dout/index  loader stream in; ioctl_wait back-pressure out
//   cpu_req/cpu_addr           CPU read request in; cpu_ack/cpu_rdata response out
//   mem_req/we/addr/wdata      memory port request out; mem_ack/mem_rdata in
//   machine_info               last index-1 byte
//   game_reset_n               low holds the game core in reset
//   dl_overflow, dl_oor        sticky download error flags
//   dl_sum                     download checksum
module rom_load_sched #(
  parameter int AW          = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROM_BYTES   = 8192,
  parameter int HOLD_CYCLES = 16
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [7:0]    ioctl_index,
  output logic          ioctl_wait,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    machine_info,
  output logic          game_reset_n,
  output logic          dl_overflow,
  output logic          dl_oor,
  output logic [7:0]    dl_sum
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LVL  = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   ROM_LIM   = (AW + 1)'(ROM_BYTES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;

  state_t        state;
  logic          dl_q;
  logic [HW-1:0] hold_cnt;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;

  logic wr_rom, in_range, push, pop, dl_rise, drain_done;
  logic cpu_rd_ok, issue_wr, issue_rd;

  assign wr_rom   = ioctl_wr && (ioctl_index == 8'd0);
  assign in_range = {1'b0, ioctl_addr} < ROM_LIM;
  assign push     = wr_rom && in_range && (count != FULL_LVL);
  assign pop      = mem_req && mem_we && mem_ack;
  assign dl_rise  = ioctl_download && !dl_q;

  assign ioctl_wait = (count >= WAIT_LVL);

  // A read is not started in the cycle cpu_ack is shown, so the CPU gets one
  // cycle to drop cpu_req before it would be taken as a fresh request.
  assign cpu_rd_ok = cpu_req && !cpu_ack;
  assign issue_wr  = !mem_req && (ioctl_wait || (!cpu_rd_ok && (count != '0)));
  assign issue_rd  = !mem_req && !ioctl_wait && cpu_rd_ok;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (!push && pop)
      count_next = count - CW'(1);
  end

  // Drain finishes on the cycle the last write is acknowledged, not one later.
  assign drain_done = (count_next == '0) && !(mem_req && mem_we && !mem_ack);

  // FIFO storage needs no reset; emptiness is carried by the pointers/count.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ioctl_addr;
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Memory port: one transaction at a time, request fields frozen while mem_req.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      if (mem_req) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= mem_rdata;
          end
        end
      end else if (issue_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end else if (issue_rd) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= cpu_addr;
      end
    end
  end

  // Download sequencer, flags and machine-select latch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dl_q         <= 1'b0;
      hold_cnt     <= '0;
      game_reset_n <= 1'b0;
      machine_info <= '0;
      dl_overflow  <= 1'b0;
      dl_oor       <= 1'b0;
    end else begin
      dl_q <= ioctl_download;

      if (ioctl_wr && (ioctl_index == 8'd1))
        machine_info <= ioctl_dout;

      dl_overflow <= (wr_rom && in_range && (count == FULL_LVL)) || (dl_overflow && !dl_rise);
      dl_oor      <= (wr_rom && !in_range) || (dl_oor && !dl_rise);

      if (dl_rise) begin
        // A new download from any state restarts loading; a pending settle is dropped.
        state        <= LOAD;
        game_reset_n <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (!ioctl_download) state <= DRAIN;
          end
          DRAIN: begin
            if (drain_done) begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              state        <= RUN;
              game_reset_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      sum_q <= '0;
    else
      sum_q <= (dl_rise ? 8'h00 : sum_q) + (push ? ioctl_dout : 8'h00);
  end

  assign dl_sum = sum_q;
`else
  assign dl_sum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_load_sched.sv
// tb/tb_rom_load_sched.sv - self-checking bench for rom_load_sched
`timescale 1ns/1ps
module tb_rom_load_sched;
  localparam int AW = 16;
  localparam int HC = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0, ioctl_index = '0;
  logic          ioctl_wait;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic [7:0]    machine_info, dl_sum;
  logic          game_reset_n, dl_overflow, dl_oor;

  rom_load_sched #(.AW(AW), .FIFO_DEPTH(4), .ROM_BYTES(8192), .HOLD_CYCLES(HC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .machine_info(machine_info), .game_reset_n(game_reset_n),
    .dl_overflow(dl_overflow), .dl_oor(dl_oor), .dl_sum(dl_sum)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Memory model: acks after lat cycles of visible request, logs issues and writes.
  int lat = 1;
  int rcnt = 0;
  int last_ack_cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic          iss_we_q[$];
  logic [AW-1:0] iss_addr_q[$];

  always @(posedge clk_sys) begin
    #1;
    if (!reset_n) begin
      mem_ack = 1'b0;
      rcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      rcnt = 0;
    end else if (mem_req) begin
      if (rcnt == 0) begin
        iss_we_q.push_back(mem_we);
        iss_addr_q.push_back(mem_addr);
      end
      rcnt++;
      if (rcnt >= lat) begin
        mem_ack = 1'b1;
        last_ack_cyc = cyc;
        mem_rdata = mem_we ? 8'h00 : rom_byte(mem_addr);
        if (mem_we) begin
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic ioctl_pulse(input logic [7:0] idx, input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  typedef struct {
    logic [7:0]    idx;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    exp_mi;
    logic          exp_oor;
    int            exp_nwr;
  } vec_t;

  vec_t vecs[7];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
  } iss_t;

  iss_t exp_iss[5];

  initial begin
    int addr, g, errs, base, base_w, hi;
    logic [7:0] sum;

    vecs[0] = '{8'd1, 16'h0000, 8'h02, 8'h02, 1'b0, 0};
    vecs[1] = '{8'd1, 16'h0000, 8'h01, 8'h01, 1'b0, 0};
    vecs[2] = '{8'd0, 16'h0010, 8'hFF, 8'h01, 1'b0, 1};
    vecs[3] = '{8'd0, 16'h1FFF, 8'h02, 8'h01, 1'b0, 1};
    vecs[4] = '{8'd0, 16'h2000, 8'h77, 8'h01, 1'b1, 0};
    vecs[5] = '{8'd2, 16'h0005, 8'h33, 8'h01, 1'b1, 0};
    vecs[6] = '{8'd0, 16'hFFFF, 8'h44, 8'h01, 1'b1, 0};

    exp_iss[0] = '{1'b1, 16'h0300};
    exp_iss[1] = '{1'b1, 16'h0301};
    exp_iss[2] = '{1'b0, 16'h0123};
    exp_iss[3] = '{1'b1, 16'h0302};
    exp_iss[4] = '{1'b1, 16'h0303};

    // Reset values
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_game_reset_n", game_reset_n, 0);
    chk("rst_ioctl_wait", ioctl_wait, 0);
    chk("rst_machine_info", machine_info, 0);
    chk("rst_flags", {dl_overflow, dl_oor}, 0);
    chk("rst_dl_sum", dl_sum, 0);
    reset_n = 1'b1;
    tick();

    // Full 8192-byte load honouring ioctl_wait
    lat = 1;
    ioctl_download = 1'b1;
    tick();
    addr = 0; g = 0; sum = 8'h00;
    while (addr < 8192 && g < 60000) begin
      if (!ioctl_wait) begin
        ioctl_wr = 1'b1; ioctl_index = 8'd0;
        ioctl_addr = AW'(addr); ioctl_dout = pat(AW'(addr));
        sum = sum + pat(AW'(addr));
        addr++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
      g++;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    g = 0;
    while (!game_reset_n && g < 2000) begin tick(); g++; end
    chk("load_game_reset_n", game_reset_n, 1);
    chk("load_release_delay", cyc - last_ack_cyc, HC + 2);
    chk("load_write_count", wr_addr_q.size(), 8192);
    errs = 0;
    for (int i = 0; i < wr_addr_q.size() && i < 8192; i++)
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== pat(AW'(i))) errs++;
    chk("load_order", errs, 0);
    chk("load_flags", {dl_overflow, dl_oor}, 0);
`ifdef ROM_LOAD_CHECKSUM_EN
    chk("load_sum", dl_sum, sum);
`else
    chk("load_sum", dl_sum, 0);
`endif

    // Table: index handling, range check, machine select
    ioctl_download = 1'b1;
    tick();
    for (int v = 0; v < 7; v++) begin
      base = wr_addr_q.size();
      ioctl_pulse(vecs[v].idx, vecs[v].addr, vecs[v].data);
      repeat (6) tick();
      chk($sformatf("vec%0d_machine_info", v), machine_info, vecs[v].exp_mi);
      chk($sformatf("vec%0d_oor", v), dl_oor, vecs[v].exp_oor);
      chk($sformatf("vec%0d_nwr", v), wr_addr_q.size() - base, vecs[v].exp_nwr);
      if (vecs[v].exp_nwr == 1 && wr_addr_q.size() > 0)
        chk($sformatf("vec%0d_wr", v), {wr_addr_q[$], wr_data_q[$]}, {vecs[v].addr, vecs[v].data});
    end
`ifdef ROM_LOAD_CHECKSUM_EN
    chk("table_sum", dl_sum, 8'h01);
`else
    chk("table_sum", dl_sum, 8'h00);
`endif
    ioctl_download = 1'b0;
    repeat (HC + 10) tick();
    chk("table_run", game_reset_n, 1);

    // Overflow with slow memory and a loader ignoring ioctl_wait
    lat = 10;
    ioctl_download = 1'b1;
    tick();
    chk("ovf_cleared_oor", dl_oor, 0);
    base_w = wr_addr_q.size();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) chk("ovf_wait_at2", ioctl_wait, 0);
      if (k == 3) chk("ovf_wait_at3", ioctl_wait, 1);
      ioctl_wr = 1'b1; ioctl_index = 8'd0;
      ioctl_addr = AW'(16'h0100 + k); ioctl_dout = 8'h10 + 8'(k);
      tick();
    end
    ioctl_wr = 1'b0;
    chk("ovf_flag", dl_overflow, 1);
    repeat (60) tick();
    chk("ovf_nwr", wr_addr_q.size() - base_w, 4);
    errs = 0;
    for (int k = 0; k < 4; k++)
      if (base_w + k < wr_addr_q.size() && wr_addr_q[base_w + k] !== AW'(16'h0100 + k)) errs++;
    chk("ovf_order", errs, 0);
    ioctl_download = 1'b0;
    repeat (HC + 10) tick();

    // Arbitration: count 1 -> read wins
    lat = 3;
    base = iss_we_q.size();
    ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 16'h0200; ioctl_dout = 8'hA5;
    tick();
    ioctl_wr = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0777;
    tick();
    chk("arb1_req", mem_req, 1);
    chk("arb1_we", mem_we, 0);
    g = 0;
    while (!cpu_ack && g < 50) begin tick(); g++; end
    cpu_req = 1'b0;
    chk("arb1_cpu_ack", cpu_ack, 1);
    chk("arb1_rdata", cpu_rdata, rom_byte(16'h0777));
    chk("arb1_ack_lat", cyc - last_ack_cyc, 1);
    repeat (10) tick();
    chk("arb1_issues", iss_we_q.size() - base, 2);
    if (iss_we_q.size() >= base + 2)
      chk("arb1_order", {iss_we_q[base], iss_we_q[base + 1]}, 2'b01);

    // Arbitration: count 3 -> write wins, then read at count 2
    lat = 6;
    base = iss_we_q.size();
    for (int k = 0; k < 4; k++) begin
      ioctl_wr = 1'b1; ioctl_index = 8'd0;
      ioctl_addr = AW'(16'h0300 + k); ioctl_dout = 8'hC0 + 8'(k);
      tick();
    end
    ioctl_wr = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0123;
    g = 0;
    while (!cpu_ack && g < 100) begin tick(); g++; end
    cpu_req = 1'b0;
    chk("arb3_rdata", cpu_rdata, rom_byte(16'h0123));
    repeat (30) tick();
    chk("arb3_issues", iss_we_q.size() - base, 5);
    errs = 0;
    for (int k = 0; k < 5; k++)
      if (base + k < iss_we_q.size() &&
          (iss_we_q[base + k] !== exp_iss[k].we || iss_addr_q[base + k] !== exp_iss[k].addr)) errs++;
    chk("arb3_order", errs, 0);

    // Download re-raised during HOLD
    lat = 1;
    ioctl_download = 1'b1;
    tick();
    ioctl_pulse(8'd0, 16'h2000, 8'h00);
    ioctl_pulse(8'd0, 16'h0010, 8'h11);
    tick();
    ioctl_download = 1'b0;
    repeat (8) tick();
    chk("hold_reset_low", game_reset_n, 0);
    chk("hold_oor_set", dl_oor, 1);
    ioctl_download = 1'b1;
    tick(); tick();
    chk("reload_oor_clr", dl_oor, 0);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (game_reset_n) hi++;
      tick();
    end
    chk("reload_stays_low", hi, 0);
    ioctl_download = 1'b0;
    g = 0;
    while (!game_reset_n && g < 200) begin tick(); g++; end
    chk("reload_run", game_reset_n, 1);

    // Reset in the middle of an outstanding write
    lat = 10;
    ioctl_pulse(8'd0, 16'h0400, 8'h01);
    ioctl_pulse(8'd0, 16'h0401, 8'h02);
    g = 0;
    while (!mem_req && g < 20) begin tick(); g++; end
    chk("midrst_req_before", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_outputs", {ioctl_wait, game_reset_n, dl_oor, machine_info}, 0);
    tick(); tick();
    reset_n = 1'b1;
    base = iss_we_q.size();
    repeat (20) tick();
    chk("midrst_fifo_empty", iss_we_q.size() - base, 0);
    chk("midrst_idle", game_reset_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
